// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
//
// Memory-stage access unit. Sits directly behind the execute pipeline register,
// issues loads and stores on the data bus (dbus) through a registered request
// FSM, aligns store data onto byte lanes, extracts and extends load data, and
// presents a registered result to the memory/writeback pipeline register.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned memory ops raise out_exc instead of issuing on dbus
//   undefined : no alignment check, out_exc tied low
//
// Parameters
//   XLEN            data/address width, must be 64
//
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   in_valid        execute-stage entry valid
//   in_load/store   entry is a load / store
//   in_size         0=byte 1=half 2=word 3=dword
//   in_unsigned     zero-extend load result
//   in_addr         effective address
//   in_wdata        store data, LSB-aligned
//   in_result       ALU result for non-memory entries
//   in_rd           destination register
//   stall_o         hold upstream (upstream keeps in_* stable while high)
//   dreq_*          dbus request: valid, addr, size, byte strobe, lane data
//   dresp_addr_ok   bus accepted the address
//   dresp_data_ok   bus completed the transaction
//   dresp_data      raw 64-bit read lane
//   out_valid       result valid to next stage
//   out_rd          destination register
//   out_data        writeback value
//   out_exc         misaligned exception
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | accepting entries; non-memory entries pass through in 1 cycle
// REQ       | request on dbus, waiting for addr_ok or data_ok
// WAIT_DATA | address accepted, request held until data_ok
// DONE      | result presented for one cycle, upstream released
// -----------------------------------------------------------------------------
module mem_access #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            in_valid,
    input  logic            in_load,
    input  logic            in_store,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [XLEN-1:0] in_result,
    input  logic [4:0]      in_rd,
    output logic            stall_o,

    output logic            dreq_valid,
    output logic [XLEN-1:0] dreq_addr,
    output logic [2:0]      dreq_size,
    output logic [7:0]      dreq_strobe,
    output logic [XLEN-1:0] dreq_data,
    input  logic            dresp_addr_ok,
    input  logic            dresp_data_ok,
    input  logic [XLEN-1:0] dresp_data,

    output logic            out_valid,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_data,
    output logic            out_exc
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic            mem_op;
    logic            misaligned;
    logic            trap;
    logic            issue;
    logic            finish;

    logic [7:0]      st_mask;
    logic [7:0]      st_strobe;
    logic [XLEN-1:0] st_data;

    logic            unsigned_q;
    logic [4:0]      rd_q;
    logic            store_q;

    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] load_val;

    assign mem_op = in_valid & (in_load | in_store);

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        case (in_size)
            2'd1:    misaligned = in_addr[0];
            2'd2:    misaligned = |in_addr[1:0];
            2'd3:    misaligned = |in_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    // A trapped entry is consumed in IDLE without ever touching the bus.
    assign trap = (state_q == IDLE) & mem_op & misaligned;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        issue   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                issue   = mem_op & ~misaligned;
                stall_o = issue;
                if (issue) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                stall_o = 1'b1;
                // data_ok implies the address was taken, even without addr_ok
                if (dresp_data_ok) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else if (dresp_addr_ok) begin
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                stall_o = 1'b1;
                if (dresp_data_ok) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Store lane alignment: shift data and byte mask up by the address
    // offset; bytes pushed past lane 7 are dropped.
    // ------------------------------------------------------------------
    always_comb begin
        st_mask = 8'h00;
        case (in_size)
            2'd0:    st_mask = 8'h01;
            2'd1:    st_mask = 8'h03;
            2'd2:    st_mask = 8'h0F;
            default: st_mask = 8'hFF;
        endcase
    end

    assign st_strobe = st_mask << in_addr[2:0];
    assign st_data   = in_wdata << {in_addr[2:0], 3'b000};

    // ------------------------------------------------------------------
    // Request registers. Fields are latched once at issue and held until
    // the next issue so the bus always sees stable values.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dreq_valid  <= 1'b0;
            dreq_addr   <= '0;
            dreq_size   <= 3'd0;
            dreq_strobe <= 8'h00;
            dreq_data   <= '0;
            unsigned_q  <= 1'b0;
            rd_q        <= 5'd0;
            store_q     <= 1'b0;
        end else begin
            if (issue) begin
                dreq_valid  <= 1'b1;
                dreq_addr   <= in_addr;
                dreq_size   <= {1'b0, in_size};
                dreq_strobe <= in_store ? st_strobe : 8'h00;
                dreq_data   <= st_data;
                unsigned_q  <= in_unsigned;
                rd_q        <= in_rd;
                store_q     <= in_store;
            end else if (finish) begin
                dreq_valid  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load extraction from the raw read lane, using the latched request.
    // ------------------------------------------------------------------
    assign raw = dresp_data >> {dreq_addr[2:0], 3'b000};

    always_comb begin
        load_val = raw;
        case (dreq_size[1:0])
            2'd0: load_val = unsigned_q ? {{(XLEN-8){1'b0}}, raw[7:0]}
                                        : {{(XLEN-8){raw[7]}}, raw[7:0]};
            2'd1: load_val = unsigned_q ? {{(XLEN-16){1'b0}}, raw[15:0]}
                                        : {{(XLEN-16){raw[15]}}, raw[15:0]};
            2'd2: load_val = unsigned_q ? {{(XLEN-32){1'b0}}, raw[31:0]}
                                        : {{(XLEN-32){raw[31]}}, raw[31:0]};
            default: load_val = raw;
        endcase
    end

    // ------------------------------------------------------------------
    // Result register to the memory/writeback stage.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_rd    <= 5'd0;
            out_data  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        out_valid <= 1'b0;
                    end else if (trap) begin
                        out_valid <= 1'b1;
                        out_rd    <= 5'd0;
                        out_data  <= in_addr;
                    end else begin
                        out_valid <= in_valid;
                        out_rd    <= in_rd;
                        out_data  <= in_result;
                    end
                end
                REQ, WAIT_DATA: begin
                    if (dresp_data_ok) begin
                        out_valid <= 1'b1;
                        out_rd    <= store_q ? 5'd0 : rd_q;
                        out_data  <= store_q ? '0 : load_val;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic exc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_q <= 1'b0;
        end else begin
            exc_q <= trap;
        end
    end

    assign out_exc = exc_q;
`else
    assign out_exc = 1'b0;
`endif

endmodule
